// File: rtl/dcsk_pkg.sv
// Shared DCSK message-framing constants for the modulator PISO and the demodulator SIPO.
// Bit order on the air is MSB first: the first bit sent/received is message bit [WIDTH-1].
package dcsk_pkg;

   localparam int DCSK_MSG_WIDTH = 8;

endpackage : dcsk_pkg

// File: rtl/dcsk_sipo_if.sv
// Bit-strobe input and valid/ready message output of the DCSK SIPO assembler.
// master = assembler side, slave = decision stage plus downstream consumer.
interface dcsk_sipo_if
   import dcsk_pkg::*;
#(
   parameter int MSG_WIDTH = DCSK_MSG_WIDTH
);

   logic                 bit_in;
   logic                 bit_vld;
   logic [MSG_WIDTH-1:0] msg_out;
   logic                 msg_vld;
   logic                 msg_rdy;

   modport master (
      input  bit_in,
      input  bit_vld,
      input  msg_rdy,
      output msg_out,
      output msg_vld
   );

   modport slave (
      output bit_in,
      output bit_vld,
      output msg_rdy,
      input  msg_out,
      input  msg_vld
   );

endinterface : dcsk_sipo_if

// File: rtl/dcsk_sipo.sv
// DCSK receive-side serial-in parallel-out message assembler, MSB first.
// A completed word lands in a holding register so assembly of the next word never stalls.
module dcsk_sipo
   import dcsk_pkg::*;
#(
   parameter int  MSG_WIDTH = DCSK_MSG_WIDTH,
   localparam int CNT_WIDTH = $clog2(MSG_WIDTH)
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   dcsk_sipo_if.master    bus,
   output logic           busy,
   output logic           ovf
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MSG_WIDTH - 1);

   logic [MSG_WIDTH-1:0] shift_q;
   logic [MSG_WIDTH-1:0] shift_nxt;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [MSG_WIDTH-1:0] msg_q;
   logic                 vld_q;
   logic                 ovf_q;
   logic                 done;
   logic                 out_free;
   logic                 accept;

   assign shift_nxt = {shift_q[MSG_WIDTH-2:0], bus.bit_in};
   assign done      = bus.bit_vld && (cnt_q == CNT_LAST);
   assign accept    = vld_q && bus.msg_rdy;
   // The holding register is free if empty or being drained on this very edge.
   assign out_free  = !vld_q || bus.msg_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         msg_q   <= '0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (clr) begin
         shift_q <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (bus.bit_vld) begin
            shift_q <= shift_nxt;
            cnt_q   <= done ? '0 : cnt_q + CNT_WIDTH'(1);
         end
         if (done && out_free) begin
            msg_q <= shift_nxt;
            vld_q <= 1'b1;
         end else if (done) begin
            // Output still occupied: drop the new word but keep framing.
            ovf_q <= 1'b1;
         end else if (accept) begin
            vld_q <= 1'b0;
         end
      end
   end

   assign bus.msg_out = msg_q;
   assign bus.msg_vld = vld_q;
   assign busy        = (cnt_q != '0);
   assign ovf         = ovf_q;

endmodule : dcsk_sipo

// File: doc/dcsk_sipo.md
Name: dcsk_sipo

Overview:
Serial-in parallel-out message assembler on the DCSK demodulator side; it is the receive-end counterpart of the modulator's parallel-to-serial message shifter.
- Accepts one decided bit per strobe from the correlator/decision stage, MSB first.
- Rebuilds MSG_WIDTH-bit messages.
- Presents each message on a double-buffered valid/ready output so assembly continues while a completed word waits.

Parameters:
MSG_WIDTH, 8, message width in bits; must be >= 2; bit order matches the modulator (MSB first).
CNT_WIDTH, $clog2(MSG_WIDTH), bit-counter width (derived; not overridden).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous resync: discard partial word, output word and ovf
bit_in  input  1  decided bit from demodulator
bit_vld  input  1  one-cycle strobe, bit_in valid this cycle
msg_out  output  MSG_WIDTH  assembled message (holding register)
msg_vld  output  1  msg_out holds an unaccepted message
msg_rdy  input  1  downstream accepts msg_out when msg_vld && msg_rdy
busy  output  1  partial word in progress (cnt != 0)
ovf  output  1  sticky: a completed word was dropped

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: shift register = 0, cnt = 0, msg_out = 0, msg_vld = 0, busy = 0, ovf = 0.
- Priority per edge: rst_n, then clr, then bit_vld/handshake.
- clr = 1: shift register, cnt, msg_vld and ovf are set to 0. msg_out may keep its value. bit_vld in the same cycle is ignored.
- Shift: on bit_vld, shift register <= {shift[MSG_WIDTH-2:0], bit_in}. The first received bit ends up as msg_out[MSG_WIDTH-1].
- Counter: cnt increments on each bit_vld, from 0 to MSG_WIDTH-1.
  - Completion = bit_vld && cnt == MSG_WIDTH-1. At completion cnt wraps to 0.
  - Non-power-of-2 widths wrap at MSG_WIDTH-1, not at the counter's natural overflow.
- Completion, output free (msg_vld == 0, or msg_vld && msg_rdy this cycle):
  - msg_out <= {shift[MSG_WIDTH-2:0], bit_in}.
  - msg_vld = 1 after that same edge, so latency from last bit strobe to msg_vld is 1 edge.
  - If the old word is accepted in the same cycle, msg_vld stays 1 with no bubble.
- Completion, output occupied (msg_vld && !msg_rdy):
  - New word is dropped.
  - msg_out and msg_vld are unchanged.
  - ovf <= 1; it is sticky until clr or reset.
  - Counter still wraps to 0, so framing is kept.
- Handshake: msg_vld && msg_rdy with no completion gives msg_vld <= 0 next edge.
  - msg_out must stay stable while msg_vld && !msg_rdy.
  - msg_rdy while msg_vld == 0 has no effect.
- busy is combinational, = (cnt != 0).
- bit_vld back-to-back every cycle must be supported, giving one word per MSG_WIDTH cycles with no loss if msg_rdy is held at 1.
- Reset mid-word: partial bits are lost; the next bit_vld starts a new word at MSB.
- No combinational path from msg_rdy to msg_vld or msg_out.

Decomposition:
- dcsk_pkg holds the default message-width constant DCSK_MSG_WIDTH = 8, shared with the modulator PISO so both ends agree.
- The bit-order convention (MSB first) is documented alongside it.
- No sub-module: counter, shift register and holding register fit in one module of roughly 120-150 lines.

Test Plan:
1. Reset then 8 strobes of 1,0,1,0,0,1,0,1 with msg_rdy = 1 -> msg_vld pulses one cycle after 8th strobe, msg_out = 0xA5, ovf = 0.
2. Strobes every cycle for words 0x3C, 0xC3 with msg_rdy = 1 -> two msg_vld words in order 0x3C, 0xC3, each 1 edge after its last bit; busy low only between words.
3. msg_rdy = 0, send 0x11 then 0x22 -> msg_out stays 0x11, ovf = 1 after 16th strobe. Then msg_rdy = 1 -> 0x11 accepted, msg_vld = 0, ovf stays 1.
4. Hold 0x55 unaccepted; raise msg_rdy exactly on the completion cycle of 0xAA -> 0x55 consumed, msg_out = 0xAA, msg_vld continuously 1, ovf = 0.
5. After 3 bits, pulse clr together with bit_vld, then send 0x81 -> cnt restarts, msg_out = 0x81, busy = 0 after clr, ovf cleared.
6. Assert rst_n low asynchronously mid-word (between edges) with msg_vld = 1 -> all outputs 0 immediately; next 8 strobes of 0xF0 -> msg_out = 0xF0.
